// File: rtl/scbuf_pkg.sv
`default_nettype none
// ============================================================================
// Package     : scbuf_pkg
// Description : Shared widths, return-path state encoding and error-bit
//               indices for the scbuf fill/return line stage.
// Revision    : 1.0 - initial release
// ============================================================================
package scbuf_pkg;

    // One line is 16 ECC words of 39 bits, moved as 4 beats of 4 words.
    localparam int LINE_W     = 624;
    localparam int NBEAT      = 4;
    localparam int BEAT_W     = LINE_W / NBEAT;
    localparam int BEAT_IDX_W = $clog2(NBEAT);

    // Sticky error vector bit positions.
    localparam int ERR_FLOW   = 0;  // fill overflow or fill-buffer read underflow
    localparam int ERR_COLL   = 1;  // new return line while the previous one is mid-flight

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } ret_state_e;

endpackage
`default_nettype wire

// File: rtl/scbuf_line_serdes.sv
`default_nettype none
// ============================================================================
// Module      : scbuf_line_serdes
// Description : Beat counter plus line-to-beat slice mux. The counter walks
//               0..NBEAT-1 on each advance and wraps; slice_o presents the
//               beat of line_i selected by the current count.
// Ports       : clk_i   - clock
//               rst_i   - synchronous active-high reset (count -> 0)
//               adv_i   - advance the beat counter this cycle
//               line_i  - full line to slice
//               beat_o  - current beat index
//               last_o  - current beat is the final beat of the line
//               slice_o - line_i beat selected by beat_o
// Revision    : 1.0 - initial release
// ============================================================================
module scbuf_line_serdes #(
    parameter  int LINE_W = 624,
    parameter  int NBEAT  = 4,
    localparam int BEAT_W = LINE_W / NBEAT,
    localparam int IDX_W  = (NBEAT > 1) ? $clog2(NBEAT) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              adv_i,
    input  logic [LINE_W-1:0] line_i,
    output logic [IDX_W-1:0]  beat_o,
    output logic              last_o,
    output logic [BEAT_W-1:0] slice_o
);

    logic [IDX_W-1:0]  beat_q;
    logic [IDX_W-1:0]  beat_d;
    logic [BEAT_W-1:0] w_slices [NBEAT];

    assign last_o = (beat_q == IDX_W'(NBEAT - 1));
    assign beat_o = beat_q;

    always_comb begin
        beat_d = beat_q;
        if (adv_i) begin
            beat_d = last_o ? '0 : beat_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end

    for (genvar g = 0; g < NBEAT; g++) begin : g_slice
        assign w_slices[g] = line_i[g*BEAT_W +: BEAT_W];
    end

    assign slice_o = w_slices[beat_q];

endmodule
`default_nettype wire

// File: rtl/scbuf_fb_line_stage.sv
`default_nettype none
// ============================================================================
// Module      : scbuf_fb_line_stage
// Description : scbuf-side line staging. Fill direction assembles 4 DRAM
//               beats into 624-bit lines held in a 2-entry ping-pong buffer
//               and hands a line to scdata one cycle after an sctag read
//               request. Return direction captures a 624-bit scdata line and
//               serialises it as 4 beats, back-to-back capable.
// Ports       : rclk                     - clock
//               rst                      - synchronous active-high reset
//               dram_scbuf_data_r2       - fill beat data (156b)
//               dram_scbuf_data_vld_r2   - fill beat valid
//               scbuf_dram_rdy           - current write entry is not full
//               sctag_scbuf_fbrd_c3      - fill-buffer read request
//               scbuf_scdata_fbdecc_c4   - fill line to scdata (held)
//               scbuf_scdata_fbvld_c4    - fbdecc_c4 valid
//               scdata_scbuf_decc_out_c7 - read line from scdata
//               sctag_scbuf_rdvld_c7     - decc_out_c7 valid
//               scbuf_ret_data           - serialised return beat
//               scbuf_ret_vld            - return beat valid
//               scbuf_ret_beat           - return beat index
//               scbuf_err                - sticky errors {collision, flow}
// Revision    : 1.0 - initial release
// ============================================================================
module scbuf_fb_line_stage
    import scbuf_pkg::*;
(
    input  logic                  rclk,
    input  logic                  rst,
    input  logic [BEAT_W-1:0]     dram_scbuf_data_r2,
    input  logic                  dram_scbuf_data_vld_r2,
    output logic                  scbuf_dram_rdy,
    input  logic                  sctag_scbuf_fbrd_c3,
    output logic [LINE_W-1:0]     scbuf_scdata_fbdecc_c4,
    output logic                  scbuf_scdata_fbvld_c4,
    input  logic [LINE_W-1:0]     scdata_scbuf_decc_out_c7,
    input  logic                  sctag_scbuf_rdvld_c7,
    output logic [BEAT_W-1:0]     scbuf_ret_data,
    output logic                  scbuf_ret_vld,
    output logic [BEAT_IDX_W-1:0] scbuf_ret_beat,
    output logic [1:0]            scbuf_err
);

    // ------------------------------------------------------------------
    // Fill buffer state
    // ------------------------------------------------------------------
    logic [LINE_W-1:0]     entry_q [2];
    logic [1:0]            full_q;
    logic [1:0]            full_d;
    logic                  wr_ptr_q;
    logic                  wr_ptr_d;
    logic                  rd_ptr_q;
    logic                  rd_ptr_d;
    logic [LINE_W-1:0]     fbdecc_q;
    logic [LINE_W-1:0]     fbdecc_d;
    logic                  fbvld_q;
    logic [1:0]            err_q;
    logic [1:0]            err_d;

    logic                  w_fill_acc;
    logic                  w_fill_ovf;
    logic                  w_fill_done;
    logic                  w_fill_last;
    logic [BEAT_IDX_W-1:0] w_fill_beat;
    logic [BEAT_W-1:0]     w_fill_slice_unused;
    logic                  w_rd_hit;
    logic                  w_rd_miss;

    // ------------------------------------------------------------------
    // Return path state
    // ------------------------------------------------------------------
    ret_state_e            state_q;
    ret_state_e            state_d;
    logic [LINE_W-1:0]     ret_buf_q;
    logic                  w_ret_adv;
    logic                  w_ret_last;
    logic                  w_ret_take;
    logic                  w_ret_coll;
    logic [BEAT_IDX_W-1:0] w_ret_beat;
    logic [BEAT_W-1:0]     w_ret_slice;

    // ------------------------------------------------------------------
    // Fill assembly
    // ------------------------------------------------------------------
    // All decisions use pre-edge full flags, so a line completing this
    // cycle is not yet visible to a same-cycle read of that entry.
    assign w_fill_acc  = dram_scbuf_data_vld_r2 & ~full_q[wr_ptr_q];
    assign w_fill_ovf  = dram_scbuf_data_vld_r2 &  full_q[wr_ptr_q];
    assign w_fill_done = w_fill_acc & w_fill_last;
    assign w_rd_hit    = sctag_scbuf_fbrd_c3 &  full_q[rd_ptr_q];
    assign w_rd_miss   = sctag_scbuf_fbrd_c3 & ~full_q[rd_ptr_q];

    scbuf_line_serdes #(
        .LINE_W (LINE_W),
        .NBEAT  (NBEAT)
    ) u_fill_serdes (
        .clk_i   (rclk),
        .rst_i   (rst),
        .adv_i   (w_fill_acc),
        .line_i  (entry_q[wr_ptr_q]),
        .beat_o  (w_fill_beat),
        .last_o  (w_fill_last),
        .slice_o (w_fill_slice_unused)
    );

    // A completing write targets an empty entry and a hitting read targets
    // a full one, so the set and clear below never address the same entry.
    always_comb begin
        full_d   = full_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fbdecc_d = fbdecc_q;
        if (w_rd_hit) begin
            full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = ~rd_ptr_q;
            fbdecc_d         = entry_q[rd_ptr_q];
        end
        if (w_fill_done) begin
            full_d[wr_ptr_q] = 1'b1;
            wr_ptr_d         = ~wr_ptr_q;
        end
    end

    // Line storage carries no reset: a line is only readable once all four
    // beats have been rewritten, so stale contents are never observed.
    always_ff @(posedge rclk) begin
        if (w_fill_acc) begin
            entry_q[wr_ptr_q][int'(w_fill_beat)*BEAT_W +: BEAT_W] <= dram_scbuf_data_r2;
        end
    end

    // ------------------------------------------------------------------
    // Return serialisation
    // ------------------------------------------------------------------
    assign w_ret_adv  = (state_q == SEND);
    // A new line is taken when idle, or on the final beat for a seamless
    // follow-on stream; anywhere else it would corrupt the line in flight.
    assign w_ret_take = sctag_scbuf_rdvld_c7 & ((state_q == IDLE) | w_ret_last);
    assign w_ret_coll = sctag_scbuf_rdvld_c7 & (state_q == SEND) & ~w_ret_last;

    scbuf_line_serdes #(
        .LINE_W (LINE_W),
        .NBEAT  (NBEAT)
    ) u_ret_serdes (
        .clk_i   (rclk),
        .rst_i   (rst),
        .adv_i   (w_ret_adv),
        .line_i  (ret_buf_q),
        .beat_o  (w_ret_beat),
        .last_o  (w_ret_last),
        .slice_o (w_ret_slice)
    );

    always_comb begin
        state_d        = state_q;
        scbuf_ret_vld  = 1'b0;
        scbuf_ret_data = '0;
        scbuf_ret_beat = '0;
        case (state_q)
            IDLE: begin
                if (sctag_scbuf_rdvld_c7) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                scbuf_ret_vld  = 1'b1;
                scbuf_ret_data = w_ret_slice;
                scbuf_ret_beat = w_ret_beat;
                if (w_ret_last && !sctag_scbuf_rdvld_c7) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (w_ret_take) begin
            ret_buf_q <= scdata_scbuf_decc_out_c7;
        end
    end

    // ------------------------------------------------------------------
    // Errors and control registers
    // ------------------------------------------------------------------
    always_comb begin
        err_d           = err_q;
        err_d[ERR_FLOW] = err_q[ERR_FLOW] | w_fill_ovf | w_rd_miss;
        err_d[ERR_COLL] = err_q[ERR_COLL] | w_ret_coll;
    end

    always_ff @(posedge rclk) begin
        if (rst) begin
            full_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            fbdecc_q <= '0;
            fbvld_q  <= 1'b0;
            err_q    <= '0;
            state_q  <= IDLE;
        end else begin
            full_q   <= full_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fbdecc_q <= fbdecc_d;
            fbvld_q  <= w_rd_hit;
            err_q    <= err_d;
            state_q  <= state_d;
        end
    end

    assign scbuf_dram_rdy         = ~full_q[wr_ptr_q];
    assign scbuf_scdata_fbdecc_c4 = fbdecc_q;
    assign scbuf_scdata_fbvld_c4  = fbvld_q;
    assign scbuf_err              = err_q;

endmodule
`default_nettype wire
